// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage pipeline.
// Owns the PC and keeps at most one instruction-memory request outstanding.
// A one-entry hold buffer absorbs a response that arrives while decode is
// stalled. Taken branches from EX redirect the PC and squash wrong-path work.
// Optional: define FETCH_PERF_CNT_EN to add the perf_fetched/perf_squashed
// saturating event counters.

module fetch_stage #(
  parameter int PC_W   = 64,
  parameter int INSN_W = 32,
  parameter int PC_INC = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [PC_W-1:0]   startpc,
  output logic [PC_W-1:0]   currentpc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              ifid_valid,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [INSN_W-1:0] ifid_insn
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed
`endif
);

  // REQ: request on the bus; WAIT: request accepted, response pending;
  // HOLD: response parked in the hold buffer; DROP: discard next response.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   hold_pc;
  logic [INSN_W-1:0] hold_insn;
  logic              handshake;
  logic              slot_free;
  logic [PC_W-1:0]   pc_seq;

  // The request is a pure decode of the state register, so it never glitches
  // and is high only while nothing is outstanding.
  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = currentpc;
  assign handshake      = imem_req_valid && imem_req_ready;
  assign slot_free      = !ifid_valid || !id_stall;
  // Sequential PC wraps modulo 2^PC_W by plain truncation.
  assign pc_seq         = currentpc + PC_W'(PC_INC);

  // Fetch FSM, PC register, IF/ID register and hold buffer.
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; later branches deliberately override the drain.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= S_REQ;
      currentpc  <= startpc;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_insn  <= '0;
      hold_pc    <= '0;
      hold_insn  <= '0;
    end else if (redirect_valid) begin
      // Redirect kills IF/ID and the hold buffer (its validity is the HOLD
      // state itself) and decides whether an in-flight response must be eaten.
      currentpc  <= redirect_pc;
      ifid_valid <= 1'b0;
      unique case (state)
        S_REQ:   state <= handshake      ? S_DROP : S_REQ;
        S_WAIT:  state <= imem_rsp_valid ? S_REQ  : S_DROP;
        S_HOLD:  state <= S_REQ;
        S_DROP:  state <= imem_rsp_valid ? S_REQ  : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      // Decode consumed the instruction and nothing replaces it.
      if (ifid_valid && !id_stall) ifid_valid <= 1'b0;
      unique case (state)
        S_REQ: begin
          if (handshake) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            currentpc <= pc_seq;
            if (slot_free) begin
              ifid_valid <= 1'b1;
              ifid_pc    <= currentpc;
              ifid_insn  <= imem_rsp_data;
              state      <= S_REQ;
            end else begin
              hold_pc    <= currentpc;
              hold_insn  <= imem_rsp_data;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= hold_pc;
            ifid_insn  <= hold_insn;
            state      <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        fetch_load;
  logic [1:0]  squash_inc;
  logic [32:0] fetched_sum;
  logic [32:0] squashed_sum;

  // An instruction enters IF/ID either straight from memory or from HOLD.
  assign fetch_load = !redirect_valid &&
                      (((state == S_WAIT) && imem_rsp_valid && slot_free) ||
                       ((state == S_HOLD) && !id_stall));

  // Up to two instructions die in one cycle (IF/ID plus hold buffer, or
  // IF/ID plus a response arriving with the redirect).
  assign squash_inc = 2'(redirect_valid && ifid_valid) +
                      2'(redirect_valid && (state == S_HOLD)) +
                      2'(imem_rsp_valid &&
                         ((redirect_valid && (state == S_WAIT)) || (state == S_DROP)));

  assign fetched_sum  = {1'b0, perf_fetched}  + 33'(fetch_load);
  assign squashed_sum = {1'b0, perf_squashed} + 33'(squash_inc);

  // Saturating event counters; a carry out clamps the count at all-ones.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= fetched_sum[32]  ? '1 : fetched_sum[31:0];
      perf_squashed <= squashed_sum[32] ? '1 : squashed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage plus
// hand-written multi-cycle sequences driven by a small memory model.
`timescale 1ns/1ps

module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic [63:0] startpc;
  logic [63:0] currentpc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_insn;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] NO_STALL = 64'hFFFF_FFFF_FFFF_FFF0;

  fetch_stage dut (
    .CLK            (CLK),
    .reset          (reset),
    .startpc        (startpc),
    .currentpc      (currentpc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_insn      (ifid_insn)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_squashed  (perf_squashed)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        ready;
    logic        rsp_v;
    logic [31:0] data;
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
    logic        e_req;
    logic [63:0] e_cpc;
    logic        e_v;
    logic [63:0] e_pc;
    logic [31:0] e_insn;
  } vec_t;

  vec_t vecs[26];

  // Results collected by the memory-model runner.
  logic [63:0] ld_pc[$];
  logic [31:0] ld_insn[$];
  int          ld_cyc[$];
  int          acc_cyc[$];
  int          overlap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [63:0] spc);
    reset          = 1'b1;
    startpc        = spc;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  // Apply one cycle of inputs; return just after the clock edge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic st, input logic rdr, input logic [63:0] rp);
    @(negedge CLK);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    id_stall       = st;
    redirect_valid = rdr;
    redirect_pc    = rp;
    @(posedge CLK);
    #1;
  endtask

  // Memory with a fixed accept-to-response delay d (1 = zero-wait) returning
  // insn = addr | 0xA0000000. Optionally stalls decode for stall_len cycles
  // once stall_pc first appears in IF/ID. Stops after n_fetch IF/ID loads.
  task automatic run_mem(input int d, input int n_fetch, input logic [63:0] stall_pc,
                         input int stall_len, input int budget);
    int          cyc = 0;
    int          cnt = 0;
    int          stall_left = 0;
    bit          outstanding = 1'b0;
    bit          stall_done = 1'b0;
    bit          accepted;
    bit          stalled_edge;
    bit          prev_v;
    logic [63:0] pend_addr = '0;
    logic [63:0] acc_addr;
    ld_pc.delete(); ld_insn.delete(); ld_cyc.delete(); acc_cyc.delete();
    overlap = 0;
    prev_v  = ifid_valid;
    while (ld_pc.size() < n_fetch && cyc < budget) begin
      @(negedge CLK);
      imem_req_ready = 1'b1;
      imem_rsp_valid = outstanding && (cnt == 1);
      imem_rsp_data  = pend_addr[31:0] | 32'hA000_0000;
      id_stall       = (stall_left > 0);
      redirect_valid = 1'b0;
      if (imem_req_valid && outstanding) overlap++;
      accepted     = imem_req_valid && imem_req_ready;
      acc_addr     = imem_addr;
      stalled_edge = id_stall;
      @(posedge CLK);
      if (imem_rsp_valid) outstanding = 1'b0;
      else if (cnt > 1) cnt--;
      if (accepted) begin
        outstanding = 1'b1;
        cnt         = d;
        pend_addr   = acc_addr;
        acc_cyc.push_back(cyc);
      end
      if (stall_left > 0) stall_left--;
      cyc++;
      #1;
      if (ifid_valid && !(prev_v && stalled_edge)) begin
        ld_pc.push_back(ifid_pc);
        ld_insn.push_back(ifid_insn);
        ld_cyc.push_back(cyc);
        if (ifid_pc == stall_pc && !stall_done) begin
          stall_left = stall_len;
          stall_done = 1'b1;
        end
      end
      prev_v = ifid_valid;
    end
  endtask

  initial begin
    // ready, rsp_v, data, stall, redir, rpc | req, cpc, ifid_v, ifid_pc, ifid_insn
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,   1'b1, 64'h200, 1'b0, 64'h0,   32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,   1'b0, 64'h200, 1'b0, 64'h0,   32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,   1'b0, 64'h200, 1'b0, 64'h0,   32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 64'h0,   1'b1, 64'h204, 1'b1, 64'h200, 32'h11111111};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 64'h0,   1'b0, 64'h204, 1'b1, 64'h200, 32'h11111111};
    vecs[5]  = '{1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0, 64'h0,   1'b0, 64'h208, 1'b1, 64'h200, 32'h11111111};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 64'h0,   1'b0, 64'h208, 1'b1, 64'h200, 32'h11111111};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,   1'b1, 64'h208, 1'b1, 64'h204, 32'h22222222};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,   1'b0, 64'h208, 1'b0, 64'h204, 32'h22222222};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 64'h301, 1'b0, 64'h301, 1'b0, 64'h204, 32'h22222222};
    vecs[10] = '{1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, 64'h0,   1'b1, 64'h301, 1'b0, 64'h204, 32'h22222222};
    vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,   1'b0, 64'h301, 1'b0, 64'h204, 32'h22222222};
    vecs[12] = '{1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 64'h0,   1'b1, 64'h305, 1'b1, 64'h301, 32'h44444444};
    vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 64'h400, 1'b0, 64'h400, 1'b0, 64'h301, 32'h44444444};
    vecs[14] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 64'h500, 1'b1, 64'h500, 1'b0, 64'h301, 32'h44444444};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 64'h600, 1'b1, 64'h600, 1'b0, 64'h301, 32'h44444444};
    vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,   1'b0, 64'h600, 1'b0, 64'h301, 32'h44444444};
    vecs[17] = '{1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1, 64'h700, 1'b1, 64'h700, 1'b0, 64'h301, 32'h44444444};
    vecs[18] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,   1'b0, 64'h700, 1'b0, 64'h301, 32'h44444444};
    vecs[19] = '{1'b0, 1'b1, 32'h66666666, 1'b0, 1'b0, 64'h0,   1'b1, 64'h704, 1'b1, 64'h700, 32'h66666666};
    vecs[20] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 64'h0,   1'b0, 64'h704, 1'b1, 64'h700, 32'h66666666};
    vecs[21] = '{1'b0, 1'b1, 32'h77777777, 1'b1, 1'b0, 64'h0,   1'b0, 64'h708, 1'b1, 64'h700, 32'h66666666};
    vecs[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 64'h800, 1'b1, 64'h800, 1'b0, 64'h700, 32'h66666666};
    vecs[23] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC,
                 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h700, 32'h66666666};
    vecs[24] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,
                 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h700, 32'h66666666};
    vecs[25] = '{1'b0, 1'b1, 32'h88888888, 1'b0, 1'b0, 64'h0,
                 1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h88888888};

    // Reset state.
    do_reset(64'h200);
    check("rst.cpc",   currentpc,      64'h200);
    check("rst.req",   imem_req_valid, 64'h1);
    check("rst.addr",  imem_addr,      64'h200);
    check("rst.v",     ifid_valid,     64'h0);
    check("rst.pc",    ifid_pc,        64'h0);
    check("rst.insn",  ifid_insn,      64'h0);

    // Table-driven cycle vectors.
    for (int i = 0; i < 26; i++) begin
      step(vecs[i].ready, vecs[i].rsp_v, vecs[i].data, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      check($sformatf("v%0d.req", i),  imem_req_valid, 64'(vecs[i].e_req));
      check($sformatf("v%0d.cpc", i),  currentpc,      vecs[i].e_cpc);
      check($sformatf("v%0d.v", i),    ifid_valid,     64'(vecs[i].e_v));
      check($sformatf("v%0d.pc", i),   ifid_pc,        vecs[i].e_pc);
      check($sformatf("v%0d.insn", i), ifid_insn,      64'(vecs[i].e_insn));
    end

    // Zero-wait memory: 13 fetches from 0, one every 2 cycles.
    do_reset(64'h0);
    run_mem(1, 13, NO_STALL, 0, 200);
    check("zw.count", 64'(ld_pc.size()), 64'd13);
    check("zw.cpc",   currentpc,         64'h34);
    check("zw.overlap", 64'(overlap),    64'd0);
    for (int i = 0; i < ld_pc.size(); i++) begin
      check($sformatf("zw.pc%0d", i),   ld_pc[i],   64'(4 * i));
      check($sformatf("zw.insn%0d", i), 64'(ld_insn[i]), 64'(32'hA000_0000 | 32'(4 * i)));
      if (i > 0) check($sformatf("zw.gap%0d", i), 64'(ld_cyc[i] - ld_cyc[i-1]), 64'd2);
    end

    // 3-cycle memory: IF/ID rises 4 cycles after each accept.
    do_reset(64'h100);
    run_mem(3, 4, NO_STALL, 0, 200);
    check("lat.count",   64'(ld_pc.size()), 64'd4);
    check("lat.overlap", 64'(overlap),      64'd0);
    for (int i = 0; i < ld_pc.size() && i < acc_cyc.size(); i++) begin
      check($sformatf("lat.pc%0d", i),  ld_pc[i], 64'h100 + 64'(4 * i));
      check($sformatf("lat.dly%0d", i), 64'(ld_cyc[i] - acc_cyc[i]), 64'd4);
    end

    // Decode stall for 5 cycles while 0x8 sits in IF/ID; 0xC parks in HOLD.
    do_reset(64'h0);
    run_mem(1, 5, 64'h8, 5, 300);
    check("stl.count",   64'(ld_pc.size()), 64'd5);
    check("stl.overlap", 64'(overlap),      64'd0);
    for (int i = 0; i < ld_pc.size(); i++)
      check($sformatf("stl.pc%0d", i), ld_pc[i], 64'(4 * i));
    if (ld_cyc.size() >= 4)
      check("stl.release_gap", 64'(ld_cyc[3] - ld_cyc[2]), 64'd6);

    // Redirect to 0x64 in WAIT; stale response arrives two cycles later.
    do_reset(64'h50);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("rd.wait_req", imem_req_valid, 64'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h64);
    check("rd.cpc",      currentpc,      64'h64);
    check("rd.drop_req", imem_req_valid, 64'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("rd.drop2_req", imem_req_valid, 64'h0);
    step(1'b0, 1'b1, 32'hA000_0050, 1'b0, 1'b0, 64'h0);
    check("rd.stale_v",  ifid_valid,     64'h0);
    check("rd.req",      imem_req_valid, 64'h1);
    check("rd.addr",     imem_addr,      64'h64);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 32'hA000_0064, 1'b0, 1'b0, 64'h0);
    check("rd.ifid_v",    ifid_valid, 64'h1);
    check("rd.ifid_pc",   ifid_pc,    64'h64);
    check("rd.ifid_insn", ifid_insn,  64'hA000_0064);

    // Asynchronous reset in the middle of a WAIT with a live IF/ID entry.
    do_reset(64'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    check("ar.pre_v", ifid_valid, 64'h1);
    startpc = 64'h40;
    #2;
    reset = 1'b1;
    #1;
    check("ar.v",    ifid_valid,     64'h0);
    check("ar.pc",   ifid_pc,        64'h0);
    check("ar.insn", ifid_insn,      64'h0);
    check("ar.cpc",  currentpc,      64'h40);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    check("ar.req",  imem_req_valid, 64'h1);
    check("ar.addr", imem_addr,      64'h40);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 32'hA000_0040, 1'b0, 1'b0, 64'h0);
    check("ar.first_pc", ifid_pc, 64'h40);

`ifdef FETCH_PERF_CNT_EN
    // 10 fetches, then squash IF/ID and HOLD together.
    do_reset(64'h0);
    run_mem(1, 10, NO_STALL, 0, 200);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b1, 32'hA000_0028, 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h900);
    check("perf.fetched",  64'(perf_fetched),  64'd10);
    check("perf.squashed", 64'(perf_squashed), 64'd2);
    check("perf.ifid_v",   ifid_valid,         64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipeline; sits directly upstream of decode and drives the IF/ID pipeline register.
- Owns the PC: loads startpc on reset, issues one instruction-memory request at a time over a valid/ready handshake, and absorbs variable memory latency.
- Honours decode back-pressure (id_stall) and branch redirects from EX (redirect_valid), squashing wrong-path instructions.

Parameters:
- PC_W, 64, PC and address width.
- INSN_W, 32, instruction width.
- PC_INC, 4, byte increment between sequential instructions.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- startpc  in  PC_W  PC value loaded while reset is high.
- currentpc  out  PC_W  PC of the next fetch (PC register).
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  PC_W  request address; equals currentpc.
- imem_rsp_valid  in  1  response valid; always accepted, at most one per request.
- imem_rsp_data  in  INSN_W  fetched instruction.
- id_stall  in  1  decode cannot accept; hold IF/ID contents.
- redirect_valid  in  1  taken branch or jump from EX.
- redirect_pc  in  PC_W  redirect target.
- ifid_valid  out  1  IF/ID register holds a live instruction.
- ifid_pc  out  PC_W  PC of ifid_insn.
- ifid_insn  out  INSN_W  instruction to decode.

Behaviour:
- Reset (asynchronous, any state):
  - currentpc=startpc; state=REQ.
  - ifid_valid=0, ifid_pc=0, ifid_insn=0.
  - Hold buffer cleared.
  - Any in-flight response is forgotten. The memory is reset on the same reset, so no stale response arrives.
- FSM states: REQ, WAIT, HOLD, DROP.
  - REQ:
    - imem_req_valid=1, imem_addr=currentpc.
    - On valid&&ready: go to WAIT.
  - WAIT:
    - imem_req_valid=0.
    - On imem_rsp_valid with the IF/ID slot free (ifid_valid==0 or id_stall==0): ifid_valid=1, ifid_pc=currentpc, ifid_insn=rsp_data; currentpc+=PC_INC; go to REQ.
    - On imem_rsp_valid with the slot blocked (ifid_valid&&id_stall): capture {pc, insn} into the one-entry hold buffer; currentpc+=PC_INC; go to HOLD.
  - HOLD:
    - No request issued.
    - When id_stall==0: move the buffer into IF/ID (ifid_valid=1); go to REQ.
  - DROP:
    - No request issued.
    - Next imem_rsp_valid is discarded; go to REQ.
- IF/ID drain: when ifid_valid&&!id_stall and no new instruction loads this cycle, ifid_valid<=0 next cycle. ifid_pc and ifid_insn keep their last values.
- id_stall with ifid_valid==0 has no effect.
- Minimum latency: request accepted in cycle N, response in N+1 → ifid_valid in N+2. Sustained throughput is one instruction per 2 cycles with a zero-wait memory.
- Redirect (priority over everything except reset):
  - Always: ifid_valid<=0; hold buffer discarded; currentpc<=redirect_pc.
  - Next state from REQ with the handshake completing in the same cycle: DROP.
  - Next state from REQ otherwise: REQ.
  - Next state from WAIT with no response this cycle: DROP.
  - Next state from WAIT with a response this cycle: response discarded; REQ.
  - Next state from HOLD: REQ.
  - Next state from DROP with no response this cycle: DROP.
  - Next state from DROP with a response this cycle: REQ.
  - Redirect wins over id_stall.
- Arithmetic: PC increment is modulo 2^PC_W; wrap from all-ones to the low address without a flag. redirect_pc is used unaligned, as given.
- At most one outstanding request, ever.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, add two outputs:
  - perf_fetched (32b): increments on each instruction loaded into IF/ID.
  - perf_squashed (32b): increments on each instruction killed by redirect (IF/ID valid, hold buffer valid, or discarded response; sum per cycle).
- Both counters reset to 0, saturate at 0xFFFFFFFF, and count only when reset is low.
- When not defined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset with startpc=0x0; zero-wait memory returning insn=addr|0xA0000000 → ifid_pc sequence 0x0,0x4,0x8,…, each valid two cycles apart; currentpc reaches 0x34 after 13 fetches.
- 3-cycle memory latency; fetch 4 instructions from 0x100 → ifid_valid rises 4 cycles after each accept; imem_req_valid never high while a request is outstanding.
- id_stall held 5 cycles while ifid_pc=0x8 → IF/ID holds 0x8, pc 0xC is captured into HOLD; on release, 0xC appears the next cycle with no loss or duplication.
- redirect_pc=0x64 asserted in WAIT, with the response arriving 2 cycles later → response discarded, ifid_valid=0, next request address 0x64, next ifid_pc=0x64.
- Reset asserted mid-WAIT with startpc=0x40 → outputs clear asynchronously, before the next CLK edge; first request after release is 0x40.
- With FETCH_PERF_CNT_EN: 10 fetches, then a redirect while IF/ID and HOLD are both valid → perf_fetched=10, perf_squashed=2.
